// File: rtl/dcsk_demodulator.sv
// DCSK demodulator: stores each reference segment, correlates the following data
// segment chip by chip and decides every bit by majority. Define DCSK_DEMOD_CONF_EN to add low_conf.
module dcsk_demodulator #(
  parameter int MSG_WIDTH = 4,
  parameter int DELAY     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rx_bit,
  output logic [MSG_WIDTH-1:0] message,
  output logic                 msg_valid,
  output logic                 busy
`ifdef DCSK_DEMOD_CONF_EN
  ,
  output logic [MSG_WIDTH-1:0] low_conf
`endif
);

  localparam int CW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam int BW = (MSG_WIDTH > 1) ? $clog2(MSG_WIDTH) : 1;
  localparam int MW = $clog2(DELAY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REF  = 2'd1,
    DATA = 2'd2
  } state_e;

  // Handshake: no back-pressure. start is taken only in IDLE; msg_valid is a
  // one-cycle pulse and message stays stable until the next msg_valid.
  state_e                 state_q, state_d;
  logic [CW-1:0]          chip_cnt_q, chip_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [MW-1:0]          match_cnt_q, match_cnt_d;
  logic [DELAY-1:0]       ref_q, ref_d;
  logic [MSG_WIDTH-1:0]   sh_q, sh_d;
  logic [MSG_WIDTH-1:0]   message_q, message_d;
  logic                   msg_valid_q, msg_valid_d;
  logic                   busy_q, busy_d;
  logic                   match;
  logic                   last_chip;
  logic                   decision;
  logic                   low_margin;
  int                     two_m;

  always_comb begin
    match      = ~(rx_bit ^ ref_q[chip_cnt_q]);
    last_chip  = (chip_cnt_q == CW'(DELAY - 1));
    two_m      = 2 * (int'(match_cnt_q) + int'(match));
    decision   = (two_m >= DELAY);
    // A tie counts as low confidence, as does a margin of a single chip.
    low_margin = ((two_m - DELAY) <= 1) && ((DELAY - two_m) <= 1);
  end

`ifdef DCSK_DEMOD_CONF_EN
  logic [MSG_WIDTH-1:0] conf_sh_q, conf_sh_d;
  logic [MSG_WIDTH-1:0] low_conf_q, low_conf_d;
`endif

  always_comb begin
    state_d     = state_q;
    chip_cnt_d  = chip_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    ref_d       = ref_q;
    sh_d        = sh_q;
    message_d   = message_q;
    msg_valid_d = 1'b0;
    busy_d      = (state_q != IDLE) || start;
`ifdef DCSK_DEMOD_CONF_EN
    conf_sh_d   = conf_sh_q;
    low_conf_d  = low_conf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          ref_d[0]    = rx_bit;
          bit_cnt_d   = BW'(MSG_WIDTH - 1);
          match_cnt_d = '0;
          if (DELAY == 1) begin
            chip_cnt_d = '0;
            state_d    = DATA;
          end else begin
            chip_cnt_d = CW'(1);
            state_d    = REF;
          end
        end
      end
      REF: begin
        ref_d[chip_cnt_q] = rx_bit;
        if (last_chip) begin
          chip_cnt_d = '0;
          state_d    = DATA;
        end else begin
          chip_cnt_d = chip_cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (last_chip) begin
          sh_d[bit_cnt_q] = decision;
`ifdef DCSK_DEMOD_CONF_EN
          conf_sh_d[bit_cnt_q] = low_margin;
`endif
          match_cnt_d = '0;
          chip_cnt_d  = '0;
          if (bit_cnt_q == '0) begin
            message_d   = sh_d;
            msg_valid_d = 1'b1;
`ifdef DCSK_DEMOD_CONF_EN
            low_conf_d  = conf_sh_d;
`endif
            state_d     = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q - BW'(1);
            state_d   = REF;
          end
        end else begin
          match_cnt_d = match_cnt_q + MW'(match);
          chip_cnt_d  = chip_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      chip_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
      ref_q       <= '0;
      sh_q        <= '0;
      message_q   <= '0;
      msg_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      chip_cnt_q  <= chip_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
      ref_q       <= ref_d;
      sh_q        <= sh_d;
      message_q   <= message_d;
      msg_valid_q <= msg_valid_d;
      busy_q      <= busy_d;
    end
  end

`ifdef DCSK_DEMOD_CONF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      conf_sh_q  <= '0;
      low_conf_q <= '0;
    end else begin
      conf_sh_q  <= conf_sh_d;
      low_conf_q <= low_conf_d;
    end
  end

  assign low_conf = low_conf_q;
`else
  logic unused_margin;
  assign unused_margin = low_margin;
`endif

  assign message   = message_q;
  assign msg_valid = msg_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_dcsk_demodulator.sv
// Bench for dcsk_demodulator: a DELAY=2 and a DELAY=5 instance driven by directed
// and randomized frames, checked against a chip-correlation reference model.
module tb_dcsk_demodulator;

  logic       clk = 1'b0;
  logic       rst;
  logic       start2, rx2, start5, rx5;
  logic [3:0] msg2, msg5;
  logic       mv2, mv5, busy2, busy5;
`ifdef DCSK_DEMOD_CONF_EN
  logic [3:0] lc2, lc5;
`endif

  always #5 clk = ~clk;

  dcsk_demodulator #(.MSG_WIDTH(4), .DELAY(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .rx_bit(rx2),
    .message(msg2), .msg_valid(mv2), .busy(busy2)
`ifdef DCSK_DEMOD_CONF_EN
    , .low_conf(lc2)
`endif
  );

  dcsk_demodulator #(.MSG_WIDTH(4), .DELAY(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .rx_bit(rx5),
    .message(msg5), .msg_valid(mv5), .busy(busy5)
`ifdef DCSK_DEMOD_CONF_EN
    , .low_conf(lc5)
`endif
  );

  int         nvec = 0;
  int         nerr = 0;
  int         v2 = 0;
  int         v5 = 0;
  int         nfr2 = 0;
  int         nfr5 = 0;
  logic       chips[$];
  logic [3:0] exp_q[$];
  logic [3:0] expc_q[$];
  logic [3:0] last_msg2 = '0;
  logic [3:0] last_msg5 = '0;

  // msg_valid pulse counters, compared against the number of completed frames.
  always @(negedge clk) begin
    if (!rst) begin
      if (mv2 === 1'b1) v2++;
      if (mv5 === 1'b1) v5++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] bv(input int d);
    return (d == 2) ? {busy2, mv2} : {busy5, mv5};
  endfunction

  function automatic logic [3:0] msg_of(input int d);
    return (d == 2) ? msg2 : msg5;
  endfunction

  task automatic drive(input int d, input logic st, input logic b);
    if (d == 2) begin start2 = st; rx2 = b; end
    else begin start5 = st; rx5 = b; end
    @(posedge clk);
    #1;
  endtask

  // Frame chips: for each bit MSB first, d reference chips then d data chips.
  task automatic build(input int d, input logic [3:0] msg, input logic [4:0] refc,
                       input logic [19:0] flips);
    chips.delete();
    for (int b = 3; b >= 0; b--) begin
      for (int j = 0; j < d; j++) chips.push_back(refc[d-1-j]);
      for (int j = 0; j < d; j++)
        chips.push_back((msg[b] ? refc[d-1-j] : ~refc[d-1-j]) ^ flips[b*5+j]);
    end
  endtask

  // Reference model: count agreeing chip pairs per bit and take the majority.
  task automatic model(input int d, output logic [3:0] m, output logic [3:0] c);
    for (int b = 3; b >= 0; b--) begin
      int base = (3 - b) * 2 * d;
      int mt = 0;
      for (int j = 0; j < d; j++) if (chips[base+j] === chips[base+d+j]) mt++;
      m[b] = (2 * mt >= d);
      c[b] = (2 * mt - d <= 1) && (d - 2 * mt <= 1);
    end
  endtask

  task automatic run_frame(input int d, input int mid_start_at);
    int n = chips.size();
    logic [3:0] em, ec;
    for (int i = 0; i < n; i++) begin
      drive(d, (i == 0) || (i == mid_start_at), chips[i]);
      if (i < n - 1) begin
        check("busy_no_valid_in_frame", bv(d), 2'b10);
      end else begin
        em = exp_q.pop_front();
        ec = expc_q.pop_front();
        check("valid_pulse_busy", bv(d), 2'b11);
        check("message", msg_of(d), em);
`ifdef DCSK_DEMOD_CONF_EN
        check("low_conf", (d == 2) ? lc2 : lc5, ec);
`endif
        if (d == 2) begin last_msg2 = em; nfr2++; end
        else begin last_msg5 = em; nfr5++; end
      end
    end
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 1'($urandom_range(0, 1)));
    check("idle_quiet", bv(d), 2'b00);
    check("message_held", msg_of(d), (d == 2) ? last_msg2 : last_msg5);
  endtask

  initial begin
    logic [3:0]  rm, rc, rmsg;
    logic [4:0]  rref;
    logic [19:0] fl;
    int          d;

    rst = 1'b1; start2 = 1'b0; rx2 = 1'b0; start5 = 1'b0; rx5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_msg2", msg2, 4'h0);
    check("reset_ctl2", {busy2, mv2}, 2'b00);
    check("reset_msg5", msg5, 4'h0);
    check("reset_ctl5", {busy5, mv5}, 2'b00);
`ifdef DCSK_DEMOD_CONF_EN
    check("reset_conf", {lc2, lc5}, 8'h00);
`endif
    rst = 1'b0;
    idle(2);

    // Clean frame 1011 with reference "10"
    build(2, 4'b1011, 5'b00010, 20'h0);
    exp_q.push_back(4'b1011); expc_q.push_back(4'b0000);
    run_frame(2, -1);
    idle(2);

    // Noise tolerance: one flipped chip in every data segment
    fl = '0;
    for (int b = 0; b < 4; b++) fl[b*5 + $urandom_range(0, 4)] = 1'b1;
    build(5, 4'b0110, 5'b11010, fl);
    exp_q.push_back(4'b0110); expc_q.push_back(4'b0000);
    run_frame(5, -1);
    idle(5);

    // Tie: bit 2 carries reference "10" and data "11"
    fl = '0;
    fl[10] = 1'b1;
    build(2, 4'b1011, 5'b00010, fl);
    exp_q.push_back(4'b1111); expc_q.push_back(4'b0100);
    run_frame(2, -1);
    idle(2);

    // Back-to-back frames: second start lands in the msg_valid cycle
    build(2, 4'b0101, 5'b00001, 20'h0);
    exp_q.push_back(4'b0101); expc_q.push_back(4'b0000);
    run_frame(2, -1);
    build(2, 4'b1100, 5'b00011, 20'h0);
    exp_q.push_back(4'b1100); expc_q.push_back(4'b0000);
    run_frame(2, -1);
    idle(2);
    check("pulse_count_b2b", v2, nfr2);

    // start pulsed again mid-frame is ignored
    build(2, 4'b1001, 5'b00010, 20'h0);
    exp_q.push_back(4'b1001); expc_q.push_back(4'b0000);
    run_frame(2, 5);
    idle(2);

    // Reset after chip 7 abandons the frame, then a clean frame decodes
    build(2, 4'b0110, 5'b00001, 20'h0);
    for (int i = 0; i < 7; i++) drive(2, i == 0, chips[i]);
    rst = 1'b1;
    drive(2, 1'b0, 1'b0);
    check("midrst_msg", msg2, 4'h0);
    check("midrst_ctl", {busy2, mv2}, 2'b00);
    rst = 1'b0;
    last_msg2 = '0;
    idle(2);
    build(2, 4'b1011, 5'b00010, 20'h0);
    exp_q.push_back(4'b1011); expc_q.push_back(4'b0000);
    run_frame(2, -1);
    idle(2);

    // Randomized frames on both instances, expectations from the model
    for (int k = 0; k < 12; k++) begin
      d    = (k % 2 == 1) ? 5 : 2;
      rmsg = 4'($urandom_range(0, 15));
      rref = 5'($urandom_range(0, 31));
      fl   = '0;
      for (int b = 0; b < 4; b++)
        for (int j = 0; j < d; j++) fl[b*5+j] = ($urandom_range(0, 3) == 0);
      build(d, rmsg, rref, fl);
      model(d, rm, rc);
      exp_q.push_back(rm); expc_q.push_back(rc);
      run_frame(d, (k % 3 == 0) ? int'($urandom_range(1, 4 * d * 2 - 1)) : -1);
      idle(d);
    end

    check("pulse_count_d2", v2, nfr2);
    check("pulse_count_d5", v5, nfr5);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcsk_demodulator.md
Name: dcsk_demodulator

Overview:
- Receive-side counterpart of the DCSK modulator. Recovers a MSG_WIDTH-bit message from a serial chip stream.
- Each message bit is carried as DELAY reference chips followed by DELAY data chips.
  - Data chips equal the reference chips for bit 1.
  - Data chips are the inverted reference chips for bit 0.
- The block stores the reference segment, correlates the data segment against it chip by chip, and decides each bit by majority.
- Sits between the channel/chip slicer and the RX message consumer.

Parameters:
- MSG_WIDTH, 4, bits per message; MSB is sent/decoded first; >= 1.
- DELAY, 2, chips per reference segment (also per data segment); >= 1.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  frame start; the cycle that samples start=1 in IDLE also samples reference chip 0 of bit MSG_WIDTH-1.
- rx_bit  input  1  received chip, one per cycle.
- message  output  MSG_WIDTH  last decoded message; held until the next frame completes.
- msg_valid  output  1  one-cycle pulse when message updates.
- busy  output  1  high while a frame is in progress (REF or DATA).

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: message=0, msg_valid=0, busy=0, state=IDLE, all counters, reference register and match counter cleared.
- States: IDLE, REF, DATA.
- IDLE:
  - start=1: store rx_bit as ref[0], chip_cnt=1, bit_cnt=MSG_WIDTH-1.
  - If DELAY=1, go to DATA; otherwise go to REF.
  - start=0: stay in IDLE.
- REF:
  - Each cycle store rx_bit into ref[chip_cnt] and increment chip_cnt.
  - On the cycle storing chip DELAY-1: chip_cnt=0, go to DATA.
- DATA:
  - Each cycle compare rx_bit with ref[chip_cnt]; match = XNOR of the two.
  - match_cnt accumulates matches; width $clog2(DELAY+1).
  - On the last data chip (chip_cnt=DELAY-1):
    - Final count m = match_cnt + match of the current chip.
    - Decision: bit=1 if 2*m >= DELAY, else 0. An exact tie decides 1.
    - Write the decision into shift register sh[bit_cnt]. Clear match_cnt and chip_cnt.
    - If bit_cnt=0: load message from the assembled shift value (including the bit just decided), set msg_valid=1 on the next cycle, go to IDLE.
    - Otherwise: decrement bit_cnt, go to REF.
- Timing:
  - A frame occupies exactly 2*DELAY*MSG_WIDTH input cycles, starting with the start cycle.
  - msg_valid is asserted in the cycle after the last data chip (latency 1).
  - A new start in that same cycle is accepted (back-to-back frames).
- busy: registered; 1 from the cycle after start is accepted until the cycle after the last data chip.
- start while busy is ignored; no restart, no error.
- rx_bit is don't-care in IDLE unless start=1.
- rst asserted mid-frame: frame abandoned, all outputs return to reset values next cycle; message is cleared to 0.
- msg_valid deasserts after one cycle unconditionally.

Optional Feature:
- Macro: DCSK_DEMOD_CONF_EN.
- Defined:
  - Adds output low_conf [MSG_WIDTH-1:0], reset 0, loaded together with message.
  - Bit k is 1 when message bit k was decided by an exact tie (2*m == DELAY) or by margin |2*m - DELAY| <= 1.
  - Tie decision still yields 1.
- Undefined: port and logic absent; the decision path is unchanged.

Test Plan:
- Clean frame, MSG_WIDTH=4, DELAY=2, message 1011, reference chips "10" every bit.
  - Stimulus, from start: 10 10 | 10 01 | 10 10 | 10 10.
  - Expected: message=4'b1011, msg_valid pulses exactly once, 1 cycle after chip 16; busy high for 16 cycles.
- Noise tolerance, DELAY=5, message 0110, reference 11010, one chip of every data segment flipped.
  - Expected: message=4'b0110; with DCSK_DEMOD_CONF_EN, low_conf=4'b0000.
- Tie, DELAY=2, bit with reference "10" and data "11" (m=1).
  - Expected: decoded bit 1; with DCSK_DEMOD_CONF_EN, the corresponding low_conf bit is 1.
- Back-to-back frames: second start in the same cycle msg_valid=1.
  - Expected: second message decoded correctly; no lost or extra msg_valid pulse.
- start pulsed again mid-frame.
  - Expected: ignored; first message decodes unchanged.
- rst asserted after chip 7 of a frame, then a clean frame 1011.
  - Expected: during/after reset message=0, busy=0, msg_valid=0; the clean frame then yields 1011.
